// File: rtl/gpu_pkg.sv
// Shared definitions for the tetris GPU blocks: framebuffer geometry,
// scan-counter widths, fill-engine state type and a frame bounds helper.
package gpu_pkg;

    localparam int GPU_WIDTH  = 320;
    localparam int GPU_HEIGHT = 200;
    localparam int GPU_X_W    = 9;
    localparam int GPU_Y_W    = 8;

    // Scan counters carry one extra bit so x0+w-1 / y0+h-1 never overflow.
    localparam int SCAN_X_W = GPU_X_W + 1;
    localparam int SCAN_Y_W = GPU_Y_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } fill_state_t;

    function automatic logic in_frame(
        input logic [SCAN_X_W-1:0] x,
        input logic [SCAN_Y_W-1:0] y
    );
        return (x < SCAN_X_W'(GPU_WIDTH)) && (y < SCAN_Y_W'(GPU_HEIGHT));
    endfunction

endpackage

// File: rtl/gpu_fill_engine_if.sv
// Command and framebuffer-write bundle of the fill engine.
// slave: engine side (takes commands, drives RAM port 2); master: game side.
interface gpu_fill_engine_if;
    import gpu_pkg::*;

    logic                 cmd_valid;
    logic                 cmd_ready;
    logic                 cmd_clear;
    logic [GPU_X_W-1:0]   cmd_x;
    logic [GPU_Y_W-1:0]   cmd_y;
    logic [GPU_X_W-1:0]   cmd_w;
    logic [GPU_Y_W-1:0]   cmd_h;
    logic                 cmd_color;
    logic                 busy;
    logic                 done;
    logic [GPU_X_W-1:0]   ram_x;
    logic [GPU_Y_W-1:0]   ram_y;
    logic                 ram_we;
    logic                 ram_wdata;

    modport slave (
        input  cmd_valid, cmd_clear, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
        output cmd_ready, busy, done, ram_x, ram_y, ram_we, ram_wdata
    );

    modport master (
        output cmd_valid, cmd_clear, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
        input  cmd_ready, busy, done, ram_x, ram_y, ram_we, ram_wdata
    );

endinterface

// File: rtl/gpu_raster_counter.sv
// Loadable raster walker: load latches origin and end point, each step
// advances x, wrapping to x0 and bumping y after x_end; holds on the last point.
// Ports: clk, rst, load, x0, y0, x_end, y_end, step -> x, y, last.
module gpu_raster_counter
    import gpu_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [SCAN_X_W-1:0] x0,
    input  logic [SCAN_Y_W-1:0] y0,
    input  logic [SCAN_X_W-1:0] x_end,
    input  logic [SCAN_Y_W-1:0] y_end,
    input  logic                step,
    output logic [SCAN_X_W-1:0] x,
    output logic [SCAN_Y_W-1:0] y,
    output logic                last
);

    logic [SCAN_X_W-1:0] x_q, x_d;
    logic [SCAN_Y_W-1:0] y_q, y_d;
    logic [SCAN_X_W-1:0] x0_q, x0_d;
    logic [SCAN_X_W-1:0] x_end_q, x_end_d;
    logic [SCAN_Y_W-1:0] y_end_q, y_end_d;
    logic                x_wrap;

    assign x_wrap = (x_q == x_end_q);
    assign last   = x_wrap && (y_q == y_end_q);
    assign x      = x_q;
    assign y      = y_q;

    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        x0_d    = x0_q;
        x_end_d = x_end_q;
        y_end_d = y_end_q;
        if (load) begin
            x_d     = x0;
            y_d     = y0;
            x0_d    = x0;
            x_end_d = x_end;
            y_end_d = y_end;
        end else if (step && !last) begin
            if (x_wrap) begin
                x_d = x0_q;
                y_d = y_q + SCAN_Y_W'(1);
            end else begin
                x_d = x_q + SCAN_X_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q     <= '0;
            y_q     <= '0;
            x0_q    <= '0;
            x_end_q <= '0;
            y_end_q <= '0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            x0_q    <= x0_d;
            x_end_q <= x_end_d;
            y_end_q <= y_end_d;
        end
    end

endmodule

// File: rtl/gpu_fill_engine.sv
// Rectangle-fill / screen-clear sequencer for framebuffer write port 2.
// Ports: clk, rst (async, active high), bus (gpu_fill_engine_if.slave):
//   cmd_* command handshake, busy/done status, registered ram_x/y/we/wdata.
// Optional macro GPU_FILL_CLIP_EN: suppress writes outside the 320x200 frame.
module gpu_fill_engine
    import gpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    gpu_fill_engine_if.slave   bus
);

    fill_state_t          state_q, state_d;
    logic                 scan_end_q, scan_end_d;
    logic                 color_q, color_d;
    logic [GPU_X_W-1:0]   ram_x_q, ram_x_d;
    logic [GPU_Y_W-1:0]   ram_y_q, ram_y_d;
    logic                 ram_we_q, ram_we_d;
    logic                 ram_wdata_q, ram_wdata_d;

    logic [SCAN_X_W-1:0]  ld_x0, ld_x_end;
    logic [SCAN_Y_W-1:0]  ld_y0, ld_y_end;
    logic                 ld_zero;
    logic                 load, step;
    logic [SCAN_X_W-1:0]  scan_x;
    logic [SCAN_Y_W-1:0]  scan_y;
    logic                 scan_last;
    logic                 pix_we;

    // Load values; end points use the widened counters so they cannot wrap.
    always_comb begin
        ld_x0    = '0;
        ld_y0    = '0;
        ld_x_end = SCAN_X_W'(GPU_WIDTH - 1);
        ld_y_end = SCAN_Y_W'(GPU_HEIGHT - 1);
        ld_zero  = 1'b0;
        if (!bus.cmd_clear) begin
            ld_x0    = {1'b0, bus.cmd_x};
            ld_y0    = {1'b0, bus.cmd_y};
            ld_x_end = {1'b0, bus.cmd_x} + {1'b0, bus.cmd_w} - SCAN_X_W'(1);
            ld_y_end = {1'b0, bus.cmd_y} + {1'b0, bus.cmd_h} - SCAN_Y_W'(1);
            ld_zero  = (bus.cmd_w == '0) || (bus.cmd_h == '0);
        end
    end

    gpu_raster_counter u_cnt (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .x0    (ld_x0),
        .y0    (ld_y0),
        .x_end (ld_x_end),
        .y_end (ld_y_end),
        .step  (step),
        .x     (scan_x),
        .y     (scan_y),
        .last  (scan_last)
    );

`ifdef GPU_FILL_CLIP_EN
    assign pix_we = in_frame(scan_x, scan_y);
`else
    logic unused_scan_msb;
    assign pix_we          = 1'b1;
    assign unused_scan_msb = scan_x[SCAN_X_W-1] ^ scan_y[SCAN_Y_W-1];
`endif

    // RUN spends one extra cycle after the last point is registered so the
    // final write is on the bus before FIN raises done.
    always_comb begin
        state_d     = state_q;
        scan_end_d  = scan_end_q;
        color_d     = color_q;
        ram_x_d     = ram_x_q;
        ram_y_d     = ram_y_q;
        ram_we_d    = 1'b0;
        ram_wdata_d = ram_wdata_q;
        load        = 1'b0;
        step        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    load       = 1'b1;
                    color_d    = bus.cmd_color;
                    scan_end_d = 1'b0;
                    state_d    = ld_zero ? FIN : RUN;
                end
            end
            RUN: begin
                if (!scan_end_q) begin
                    ram_x_d     = scan_x[GPU_X_W-1:0];
                    ram_y_d     = scan_y[GPU_Y_W-1:0];
                    ram_we_d    = pix_we;
                    ram_wdata_d = color_q;
                    step        = 1'b1;
                    scan_end_d  = scan_last;
                end else begin
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            scan_end_q  <= 1'b0;
            color_q     <= 1'b0;
            ram_x_q     <= '0;
            ram_y_q     <= '0;
            ram_we_q    <= 1'b0;
            ram_wdata_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            scan_end_q  <= scan_end_d;
            color_q     <= color_d;
            ram_x_q     <= ram_x_d;
            ram_y_q     <= ram_y_d;
            ram_we_q    <= ram_we_d;
            ram_wdata_q <= ram_wdata_d;
        end
    end

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.busy      = (state_q == RUN);
    assign bus.done      = (state_q == FIN);
    assign bus.ram_x     = ram_x_q;
    assign bus.ram_y     = ram_y_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_gpu_fill_engine.sv
// Scoreboard bench for gpu_fill_engine: a rectangle model queues the
// expected writes and done pulses; a monitor checks them every cycle.
module tb_gpu_fill_engine;
    import gpu_pkg::*;

    logic clk = 1'b0;
    logic rst;

    gpu_fill_engine_if bus ();

    gpu_fill_engine dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int cyc;
        int x;
        int y;
        int d;
    } wr_t;

    wr_t wq[$];
    int  dq[$];
    bit  fb[GPU_HEIGHT][GPU_WIDTH];

    function automatic void check(string name, int got, int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endfunction

    // Reference: every point of the rectangle in raster order, one per cycle
    // starting the cycle after accept; done the cycle after the last point.
    function automatic void push_cmd(int t, bit clr, int x, int y,
                                     int w, int h, bit c);
        int k;
        bit keep;
        if (clr) begin
            x = 0;
            y = 0;
            w = GPU_WIDTH;
            h = GPU_HEIGHT;
        end
        if (w == 0 || h == 0) begin
            dq.push_back(t);
            return;
        end
        k = 0;
        for (int yy = y; yy < y + h; yy++) begin
            for (int xx = x; xx < x + w; xx++) begin
                keep = 1'b1;
`ifdef GPU_FILL_CLIP_EN
                keep = (xx < GPU_WIDTH) && (yy < GPU_HEIGHT);
`endif
                if (keep)
                    wq.push_back('{t + 1 + k, xx % 512, yy % 256, int'(c)});
                k++;
            end
        end
        dq.push_back(t + w * h + 1);
    endfunction

    always @(negedge clk) begin
        wr_t e;
        int  ed;
        if (!rst) begin
            if (bus.ram_we) begin
                vectors++;
                if (wq.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_write: cyc %0d got (%0d,%0d)=%0d, expected none",
                             cyc, bus.ram_x, bus.ram_y, bus.ram_wdata);
                end else begin
                    e = wq.pop_front();
                    if (e.cyc != cyc || e.x != int'(bus.ram_x) ||
                        e.y != int'(bus.ram_y) || e.d != int'(bus.ram_wdata)) begin
                        miscompares++;
                        $display("FAIL write: got cyc %0d (%0d,%0d)=%0d, expected cyc %0d (%0d,%0d)=%0d",
                                 cyc, bus.ram_x, bus.ram_y, bus.ram_wdata,
                                 e.cyc, e.x, e.y, e.d);
                    end
                end
                if (bus.ram_x < GPU_WIDTH && bus.ram_y < GPU_HEIGHT)
                    fb[bus.ram_y][bus.ram_x] = bus.ram_wdata;
            end
            if (bus.done) begin
                vectors++;
                if (dq.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_done: got done at cyc %0d, expected none", cyc);
                end else begin
                    ed = dq.pop_front();
                    if (ed != cyc) begin
                        miscompares++;
                        $display("FAIL done_time: got cyc %0d, expected cyc %0d", cyc, ed);
                    end
                end
            end
        end
    end

    task automatic finish_tb();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    endtask

    task automatic send(input bit clr, input int x, input int y, input int w,
                        input int h, input bit c, input bit hold,
                        output int t);
        int n;
        bus.cmd_clear = clr;
        bus.cmd_x     = 9'(x);
        bus.cmd_y     = 8'(y);
        bus.cmd_w     = 9'(w);
        bus.cmd_h     = 8'(h);
        bus.cmd_color = c;
        bus.cmd_valid = 1'b1;
        n = 0;
        while (!bus.cmd_ready && n < 70000) begin
            @(negedge clk);
            n++;
        end
        if (!bus.cmd_ready) begin
            miscompares++;
            $display("FAIL accept_timeout: got cmd_ready 0, expected 1");
            finish_tb();
        end
        @(posedge clk);
        #1;
        t = cyc;
        push_cmd(t, clr, x, y, w, h, c);
        if (!hold)
            bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_drain(string name);
        for (int i = 0; i < 70000; i++) begin
            if (wq.size() == 0 && dq.size() == 0)
                break;
            @(negedge clk);
        end
        check(name, wq.size() + dq.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, ta, tb, x, y, w, h, ones;
        bus.cmd_valid = 1'b0;
        bus.cmd_clear = 1'b0;
        bus.cmd_x     = '0;
        bus.cmd_y     = '0;
        bus.cmd_w     = '0;
        bus.cmd_h     = '0;
        bus.cmd_color = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_ram_we", bus.ram_we, 0);
        check("rst_ram_x", bus.ram_x, 0);
        check("rst_ram_y", bus.ram_y, 0);
        check("rst_ram_wdata", bus.ram_wdata, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        rst = 1'b0;
        #1;
        check("rst_ready", bus.cmd_ready, 1);

        send(0, 10, 5, 3, 2, 1, 0, t);
        #1;
        check("run_busy", bus.busy, 1);
        wait_drain("drain_small");

        send(0, 40, 40, 0, 4, 1, 0, t);
        check("zero_ready_fin", bus.cmd_ready, 0);
        @(posedge clk);
        #1;
        check("zero_ready_back", bus.cmd_ready, 1);
        wait_drain("drain_zero");

        send(0, 100, 50, 5, 3, 1, 1, ta);
        send(0, 7, 9, 4, 2, 0, 0, tb);
        check("b2b_accept_cyc", tb, ta + 5 * 3 + 3);
        wait_drain("drain_b2b");

        for (int i = 0; i < 8; i++) begin
            x = $urandom_range(0, GPU_WIDTH - 1);
            y = $urandom_range(0, GPU_HEIGHT - 1);
            w = $urandom_range(0, (GPU_WIDTH - x > 12) ? 12 : GPU_WIDTH - x);
            h = $urandom_range(0, (GPU_HEIGHT - y > 6) ? 6 : GPU_HEIGHT - y);
            send(0, x, y, w, h, 1'($urandom_range(0, 1)), 0, t);
            wait_drain("drain_rand");
        end

        send(1, $urandom_range(0, 511), $urandom_range(0, 255),
             $urandom_range(0, 511), $urandom_range(0, 255), 0, 0, t);
        wait_drain("drain_clear");
        ones = 0;
        for (int yy = 0; yy < GPU_HEIGHT; yy++)
            for (int xx = 0; xx < GPU_WIDTH; xx++)
                ones += int'(fb[yy][xx]);
        check("clear_fb_ones", ones, 0);

        send(0, 20, 30, 8, 1, 1, 0, t);
        repeat (4) @(negedge clk);
        check("abort_cyc", cyc, t + 3);
        #1;
        rst = 1'b1;
        #1;
        check("abort_we", bus.ram_we, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        wq.delete();
        dq.delete();
        @(negedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        send(0, 50, 60, 2, 2, 1, 0, t);
        wait_drain("drain_after_abort");

        send(0, 318, 199, 4, 2, 1, 0, t);
        wait_drain("drain_clip");

        finish_tb();
    end

endmodule

// File: doc/gpu_fill_engine.md
Name: gpu_fill_engine

Overview:
- Rectangle-fill and screen-clear sequencer for the write port (port 2) of the 1-bit framebuffer RAM in the tetris GPU.
- Game logic issues one command (rectangle origin, size, colour, or full clear). The engine rasterises it into one pixel write per cycle on the RAM write port.
- Sits between the tetris game FSM and the framebuffer. Port 1 (VGA scan-out) is untouched.

Parameters:
- WIDTH, 320, framebuffer width in pixels; x coordinates are 9 bits.
- HEIGHT, 200, framebuffer height in pixels; y coordinates are 8 bits.

Ports:
- clk  in  1  single clock; the same clock drives the RAM write port.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  engine idle; command accepted when cmd_valid && cmd_ready at a clk rising edge.
- cmd_clear  in  1  1 = fill the whole screen (cmd_x/y/w/h ignored).
- cmd_x  in  9  rectangle left column.
- cmd_y  in  8  rectangle top row.
- cmd_w  in  9  rectangle width in pixels.
- cmd_h  in  8  rectangle height in pixels.
- cmd_color  in  1  pixel value to write.
- busy  out  1  rasterising in progress.
- done  out  1  one-cycle pulse when a command has completed.
- ram_x  out  9  write-port x; registered.
- ram_y  out  8  write-port y; registered.
- ram_we  out  1  write-port write enable; registered.
- ram_wdata  out  1  write-port data; registered.

Behaviour:
- Reset values: state IDLE; ram_x=0, ram_y=0, ram_we=0, ram_wdata=0, busy=0, done=0. cmd_ready=1 once rst deasserts.
- cmd_ready = (state==IDLE); combinational from state only, no dependency on cmd_valid.
- State IDLE:
  - On accept, latch x0, y0, w, h and colour. A clear command latches x0=0, y0=0, w=WIDTH, h=HEIGHT.
  - If w==0 or h==0, go to FIN.
  - Otherwise go to RUN, with the scan counters at (x0, y0).
- State RUN:
  - Each cycle, register ram_x/ram_y = current scan point, ram_we=1, ram_wdata=colour.
  - Advance x. After column x0+w-1, set x back to x0 and increment y.
  - After point (x0+w-1, y0+h-1), go to FIN.
  - busy=1 throughout RUN.
- State FIN: ram_we=0, done=1 for exactly one cycle, busy=0, next state IDLE. cmd_ready rises the cycle after done.
- Latency:
  - Command accepted at edge T.
  - First ram_we=1 is visible after edge T+1.
  - Exactly w*h consecutive write cycles, with no gaps.
  - done is high in the cycle after the last write.
  - A zero-area command gives done one cycle after accept, with no writes.
- Arithmetic: scan end values are computed as x0+w-1 (10-bit) and y0+h-1 (9-bit) to avoid overflow. Counters never wrap past these end values.
- Back-to-back commands: minimum of one idle (FIN) cycle between commands. cmd_valid while busy is not accepted and has no effect.
- Reset mid-operation: the command is aborted immediately (asynchronous). ram_we drops with rst, no done pulse is produced, and partially written pixels remain.
- ram_we is never high in IDLE or FIN.

Optional Feature:
- Macro: GPU_FILL_CLIP_EN.
- Defined:
  - Per-pixel clipping. ram_we is forced to 0 for any scan point with x>=WIDTH or y>=HEIGHT.
  - The scan still visits every point, so cycle count and done timing are unchanged.
- Undefined:
  - No clipping logic. The caller guarantees x0+w<=WIDTH and y0+h<=HEIGHT.
  - Out-of-range writes are issued as-is.

Decomposition:
- Package gpu_pkg:
  - localparams GPU_WIDTH=320, GPU_HEIGHT=200, GPU_X_W=9, GPU_Y_W=8.
  - State typedef fill_state_t {IDLE, RUN, FIN}.
  - Shared with the other tetris GPU blocks.
- Sub-module gpu_raster_counter:
  - Loadable x/y walker with inputs load, x0, y0, x_end, y_end, step.
  - Outputs x, y, last.
  - gpu_fill_engine instantiates it once.

Test Plan:
- Reset, then command x=10 y=5 w=3 h=2 colour=1 → writes exactly at (10,5) (11,5) (12,5) (10,6) (11,6) (12,6) on 6 consecutive cycles starting at T+1; done at T+7; ram_wdata=1.
- cmd_clear=1 colour=0 → 64000 writes covering (0,0)..(319,199) in raster order; done follows the write at (319,199); scoreboard shadow framebuffer all zero.
- w=0 h=4 → no ram_we; done one cycle after accept; cmd_ready back the following cycle.
- Second command with cmd_valid held high during RUN → not accepted until IDLE; executed afterwards with correct coordinates; exactly one done per command.
- Assert rst on the 3rd write of a w=8 h=1 fill → ram_we=0 immediately; no done; busy=0; next command runs normally.
- GPU_FILL_CLIP_EN defined, x=318 w=4 y=199 h=2 → writes only at (318,199) and (319,199); done exactly 8 cycles after the first scan cycle. Macro undefined: bench checks for no clip logic, i.e. all 8 writes issued.
